// File: rtl/vga_pkg.sv
// Shared 640x480 display constants, framebuffer geometry and the arbiter's FSM encoding.
package vga_pkg;

    localparam int HD   = 640;
    localparam int HR   = 16;
    localparam int HRet = 96;
    localparam int HL   = 48;
    localparam int VD   = 480;
    localparam int VB   = 10;
    localparam int VRet = 2;
    localparam int VT   = 33;

    localparam int H_TOTAL = HD + HR + HRet + HL;
    localparam int V_TOTAL = VD + VB + VRet + VT;

    localparam int FB_PIXELS = HD * VD;
    localparam int ADDR_W    = 19;
    localparam int DATA_W    = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DONE  = 2'd2
    } fsm_state_e;

endpackage

// File: rtl/fb_prefetch_fifo.sv
// Small synchronous FIFO holding prefetched pixels; flush empties it in one cycle.
module fb_prefetch_fifo #(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: display prefetch reads always win over the pixel writer.
module vga_fb_arbiter
    import vga_pkg::fsm_state_e, vga_pkg::ST_IDLE, vga_pkg::ST_FETCH, vga_pkg::ST_DONE;
#(
    parameter int DATA_W     = vga_pkg::DATA_W,
    parameter int ADDR_W     = vga_pkg::ADDR_W,
    parameter int FB_PIXELS  = vga_pkg::FB_PIXELS,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_sync,
    input  logic              pix_req,
    output logic [DATA_W-1:0] pix_data,
    output logic              underflow,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_PIXELS - 1);
    localparam logic [ADDR_W:0]   FB_LIMIT  = (ADDR_W + 1)'(FB_PIXELS);
    localparam logic [CNT_W:0]    OCC_LIMIT = (CNT_W + 1)'(FIFO_DEPTH);

    fsm_state_e        state_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              inflight_q;
    logic [DATA_W-1:0] pix_data_q;
    logic              underflow_q;

    logic [DATA_W-1:0] fifo_head;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic [CNT_W:0]    occupancy;
    logic              rd_issue;
    logic              wr_fire;
    logic              wr_in_range;
    logic              fifo_push;
    logic              fifo_pop;

    // Words already queued plus the one still on its way back from memory.
    assign occupancy = {1'b0, fifo_count} + (CNT_W + 1)'(inflight_q);
    assign rd_issue  = (state_q == ST_FETCH) && !frame_sync && (occupancy < OCC_LIMIT);

    assign wr_ready    = !rd_issue;
    assign wr_fire     = wr_valid && wr_ready && rst_n;
    assign wr_in_range = ({1'b0, wr_addr} < FB_LIMIT);

    // A return landing in a frame_sync cycle belongs to the old frame and is dropped.
    assign fifo_push = inflight_q && !frame_sync;
    assign fifo_pop  = pix_req && !fifo_empty && !frame_sync;

    fb_prefetch_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (frame_sync),
        .push      (fifo_push),
        .push_data (mem_rdata),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (rd_issue) begin
            mem_en   = 1'b1;
            mem_addr = rd_addr_q;
        end else if (wr_fire && wr_in_range) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = wr_addr;
            mem_wdata = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rd_addr_q   <= '0;
            inflight_q  <= 1'b0;
            pix_data_q  <= '0;
            underflow_q <= 1'b0;
        end else begin
            inflight_q <= rd_issue;

            if (frame_sync) begin
                state_q   <= ST_FETCH;
                rd_addr_q <= '0;
            end else if (rd_issue) begin
                rd_addr_q <= rd_addr_q + 1'b1;
                if (rd_addr_q == LAST_ADDR) begin
                    state_q <= ST_DONE;
                end
            end

            if (pix_req) begin
                if (fifo_pop) begin
                    pix_data_q <= fifo_head;
                end else begin
                    pix_data_q  <= '0;
                    underflow_q <= 1'b1;
                end
            end
        end
    end

    assign pix_data  = pix_data_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Scoreboard bench: randomized display/writer traffic against a frame-level pixel model.
module tb_vga_fb_arbiter;

    localparam int DW  = 12;
    localparam int AW  = 19;
    localparam int FBP = 96;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          frame_sync = 1'b0;
    logic          pix_req = 1'b0;
    logic [DW-1:0] pix_data;
    logic          underflow;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    vga_fb_arbiter #(
        .DATA_W     (DW),
        .ADDR_W     (AW),
        .FB_PIXELS  (FBP),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_sync (frame_sync),
        .pix_req    (pix_req),
        .pix_data   (pix_data),
        .underflow  (underflow),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #20 clk = ~clk;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [DW-1:0] v;
        bit            care;
        bit            uf;
    } pix_exp_t;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_exp_t;

    pix_exp_t pix_q[$];
    wr_exp_t  wr_q[$];
    pix_exp_t pe;
    wr_exp_t  we;

    logic [DW-1:0] fb_mem   [FBP];
    logic [DW-1:0] fb_model [FBP];

    int exp_rd_addr = 0;
    int reads_cnt = 0;
    int pix_idx = 0;
    bit uf_exp = 1'b0;
    bit pix_req_prev = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Framebuffer memory: one-cycle read latency.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                if (int'(mem_addr) < FBP) fb_mem[int'(mem_addr)] = mem_wdata;
            end else if (int'(mem_addr) < FBP) begin
                mem_rdata <= fb_mem[int'(mem_addr)];
            end else begin
                mem_rdata <= '0;
            end
        end
    end

    // Monitor: pixel scoreboard, read-address order, write scoreboard, arbitration rules.
    always @(negedge clk) begin
        if (!rst_n) begin
            pix_req_prev = 1'b0;
        end else begin
            if (pix_req_prev) begin
                if (pix_q.size() == 0) begin
                    check("pix_q_nonempty", 0, 1);
                end else begin
                    pe = pix_q.pop_front();
                    if (pe.care) check("pix_data", int'(pix_data), int'(pe.v));
                    check("underflow", int'(underflow), int'(pe.uf));
                    $display("pix: data=%0h exp=%0h care=%0d uf=%0d", pix_data, pe.v, pe.care, underflow);
                end
            end
            pix_req_prev = pix_req;
            if (mem_en && !mem_we) begin
                check("rd_not_in_sync", int'(frame_sync), 0);
                check("rd_addr", int'(mem_addr), exp_rd_addr);
                check("wr_ready_blocked", int'(wr_ready), 0);
                exp_rd_addr++;
                reads_cnt++;
            end
            if (mem_en && mem_we) begin
                if (wr_q.size() == 0) begin
                    check("wr_q_nonempty", 0, 1);
                end else begin
                    we = wr_q.pop_front();
                    check("wr_addr", int'(mem_addr), int'(we.a));
                    check("wr_data", int'(mem_wdata), int'(we.d));
                    $display("wr: addr=%0d data=%0h", mem_addr, mem_wdata);
                end
            end
            if (wr_valid && !(mem_en && !mem_we)) check("wr_ready_free", int'(wr_ready), 1);
            if (wr_valid && wr_ready && int'(wr_addr) >= FBP) check("oob_dropped", int'(mem_en), 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_sync();
        frame_sync = 1'b1;
        exp_rd_addr = 0;
        reads_cnt = 0;
        pix_idx = 0;
        tick();
        frame_sync = 1'b0;
    endtask

    task automatic req_pix(input bit care);
        pix_req = 1'b1;
        pix_q.push_back('{v: fb_model[pix_idx], care: care, uf: uf_exp});
        pix_idx++;
    endtask

    task automatic step(input bit wr_en);
        int r;
        if (wr_en) begin
            r = $urandom_range(0, 9);
            wr_valid = 1'b1;
            if (r == 0)      wr_addr = AW'(FBP);
            else if (r == 1) wr_addr = AW'(307200);
            else if (r == 2) wr_addr = AW'(FBP - 1);
            else             wr_addr = AW'($urandom_range(0, FBP - 1));
            wr_data = DW'($urandom);
            #1;
            if (wr_ready && int'(wr_addr) < FBP) begin
                wr_q.push_back('{a: wr_addr, d: wr_data});
                fb_model[int'(wr_addr)] = wr_data;
            end
        end
        tick();
    endtask

    task automatic run_frame(input bit care, input bit wr_en);
        int cyc;
        do_sync();
        repeat (20) step(wr_en);
        cyc = 0;
        while (pix_idx < FBP && cyc < 4000) begin
            pix_req = 1'b0;
            if ($urandom_range(0, 3) != 0) req_pix(care);
            step(wr_en);
            cyc++;
        end
        pix_req = 1'b0;
        wr_valid = 1'b0;
        check("frame_in_budget", pix_idx, FBP);
        repeat (10) tick();
        check("frame_reads", reads_cnt, FBP);
        repeat (20) tick();
        check("done_no_more_reads", reads_cnt, FBP);
    endtask

    task automatic wait_read(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (mem_en && !mem_we) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pix_data"}, int'(pix_data), 0);
        check({tag, "_underflow"}, int'(underflow), 0);
        check({tag, "_mem_en"}, int'(mem_en), 0);
        check({tag, "_mem_we"}, int'(mem_we), 0);
        check({tag, "_mem_addr"}, int'(mem_addr), 0);
        check({tag, "_mem_wdata"}, int'(mem_wdata), 0);
        check({tag, "_wr_ready"}, int'(wr_ready), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        bit seen;
        for (int i = 0; i < FBP; i++) begin
            fb_mem[i] = DW'($urandom);
            fb_model[i] = fb_mem[i];
        end

        // Reset values, with the writer active to show it cannot reach memory.
        wr_valid = 1'b1;
        wr_addr = AW'(5);
        wr_data = DW'(12'hABC);
        #5;
        check_reset_outputs("rst0");
        repeat (3) tick();
        check_reset_outputs("rst1");
        wr_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        // Prefill with no consumer: exactly DEPTH reads, then the bus goes quiet.
        do_sync();
        repeat (30) tick();
        check("prefill_reads", reads_cnt, DEPTH);
        check("prefill_mem_en", int'(mem_en), 0);
        check("prefill_wr_ready", int'(wr_ready), 1);

        // One pop, then frame_sync right after the refill read: its return must vanish.
        req_pix(1'b1);
        tick();
        pix_req = 1'b0;
        wait_read(seen);
        check("refill_read_seen", int'(seen), 1);
        tick();
        run_frame(1'b1, 1'b0);
        check("no_underflow_a", int'(underflow), 0);

        // Writer contending through a whole frame, then read everything back.
        run_frame(1'b0, 1'b1);
        run_frame(1'b1, 1'b0);
        check("no_underflow_b", int'(underflow), 0);
        check("wr_q_drained", wr_q.size(), 0);

        // Consumer starts one cycle after frame_sync: FIFO is still empty.
        do_sync();
        pix_req = 1'b1;
        uf_exp = 1'b1;
        pix_q.push_back('{v: '0, care: 1'b1, uf: 1'b1});
        tick();
        pix_req = 1'b0;
        repeat (3) tick();
        do_sync();
        tick();
        check("underflow_sticky", int'(underflow), 1);
        repeat (10) tick();

        // Reset while a read return is pending.
        do_sync();
        repeat (3) tick();
        pix_req = 1'b1;
        pix_q.push_back('{v: '0, care: 1'b0, uf: 1'b1});
        tick();
        pix_req = 1'b0;
        wait_read(seen);
        check("midframe_read_seen", int'(seen), 1);
        tick();
        wr_valid = 1'b1;
        rst_n = 1'b0;
        uf_exp = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        pix_q.delete();
        wr_q.delete();
        reads_cnt = 0;
        repeat (2) tick();
        wr_valid = 1'b0;
        rst_n = 1'b1;
        repeat (3) tick();
        pix_req = 1'b1;
        uf_exp = 1'b1;
        pix_q.push_back('{v: '0, care: 1'b1, uf: 1'b1});
        tick();
        pix_req = 1'b0;
        repeat (3) tick();
        check("idle_no_reads", reads_cnt, 0);
        check("pix_q_drained", pix_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
